cpu_io_top: RTL and testbench



---
 rtl/cpu_io_pkg.sv | 36 +++
 rtl/seg7_scan.sv | 53 +++++
 rtl/cpu_io_top.sv | 117 +++++++++++
 tb/tb_cpu_io_top.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_io_pkg.sv
// cpu_io_pkg: shared definitions for the cpu_io_top board I/O block.
//   state_t           - handshake/add FSM state encoding
//   SEG_LUT           - active-low seven-segment patterns {a,b,c,d,e,f,g}, indexed by hex digit
//   SCAN_BITS_DEFAULT - default width of the display refresh counter
package cpu_io_pkg;

    typedef enum logic [2:0] {
        WAIT_IN,
        LOAD,
        ADD,
        WAIT_OUT,
        WRITE
    } state_t;

    localparam int SCAN_BITS_DEFAULT = 18;

    localparam logic [6:0] SEG_LUT [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

endpackage

// File: rtl/seg7_scan.sv
// seg7_scan: 8-digit multiplexed seven-segment driver.
//   clk, rst - clock, asynchronous active-high reset
//   value    - 32-bit value, digit n shows value[4n+3:4n]
//   blank    - per-digit blank mask; a blanked digit keeps its AN bit high
//   an       - registered digit enables, active-low, an[0] = rightmost digit
//   seg      - registered segments, active-low, seg[6] = a ... seg[0] = g
// The digit select is the top three bits of the refresh counter, so the scan
// advances one digit every 2^(SCAN_BITS-3) cycles and wraps 7 -> 0.
module seg7_scan
    import cpu_io_pkg::*;
#(
    parameter int SCAN_BITS = SCAN_BITS_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] value,
    input  logic [7:0]  blank,
    output logic [7:0]  an,
    output logic [6:0]  seg
);

    logic [SCAN_BITS-1:0] cnt_q, cnt_d;
    logic [7:0]           an_q, an_d;
    logic [6:0]           seg_q, seg_d;
    logic [2:0]           sel;
    logic [3:0]           nibble;

    always_comb begin
        cnt_d  = cnt_q + SCAN_BITS'(1);
        sel    = cnt_q[SCAN_BITS-1 -: 3];
        nibble = value[{sel, 2'b00} +: 4];
        seg_d  = SEG_LUT[nibble];
        an_d   = blank[sel] ? 8'hFF : ~(8'b1 << sel);
    end

    // Reset outputs equal the decoded digit 0 of a zero value, so the first
    // registered update after reset does not visibly change the display.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            an_q  <= 8'b11111110;
            seg_q <= 7'b0000001;
        end else begin
            cnt_q <= cnt_d;
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;

endmodule

// File: rtl/cpu_io_top.sv
// cpu_io_top: board-level I/O block. Waits for the input-ready button, loads
// two 8-bit operands from the switches, adds them (carry kept), waits for the
// output-ready button and publishes the sum on the seven-segment display.
//   CLK100MHZ - system clock
//   BTNC      - asynchronous active-high reset
//   BTNL      - output-ready strobe (level, synchronized)
//   BTNR      - input-ready strobe (level, synchronized)
//   SW        - operands A = SW[15:8], B = SW[7:0], sampled only in LOAD
//   AN        - digit enables, active-low
//   A2G       - segments, active-low, A2G[6] = a
// Build option OPERAND_DISPLAY_EN: when defined, digits 7..6 show opA and
// digits 5..4 show opB; otherwise digits 7..4 are blanked in their slots.
module cpu_io_top
    import cpu_io_pkg::*;
#(
    parameter int SCAN_BITS = SCAN_BITS_DEFAULT
) (
    input  logic        CLK100MHZ,
    input  logic        BTNC,
    input  logic        BTNL,
    input  logic        BTNR,
    input  logic [15:0] SW,
    output logic [7:0]  AN,
    output logic [6:0]  A2G
);

    state_t      state_q, state_d;
    logic        btnl_s1_q, btnl_s1_d, btnl_s2_q, btnl_s2_d;
    logic        btnr_s1_q, btnr_s1_d, btnr_s2_q, btnr_s2_d;
    logic [7:0]  opa_q, opa_d;
    logic [7:0]  opb_q, opb_d;
    logic [8:0]  sum_q, sum_d;
    logic [15:0] result_q, result_d;
    logic [31:0] disp_value;
    logic [7:0]  disp_blank;

    always_comb begin
        btnl_s1_d = BTNL;
        btnl_s2_d = btnl_s1_q;
        btnr_s1_d = BTNR;
        btnr_s2_d = btnr_s1_q;
    end

    always_comb begin
        state_d  = state_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        sum_d    = sum_q;
        result_d = result_q;
        unique case (state_q)
            WAIT_IN: begin
                if (btnr_s2_q) state_d = LOAD;
            end
            LOAD: begin
                opa_d   = SW[15:8];
                opb_d   = SW[7:0];
                state_d = ADD;
            end
            ADD: begin
                sum_d   = {1'b0, opa_q} + {1'b0, opb_q};
                state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (btnl_s2_q) state_d = WRITE;
            end
            WRITE: begin
                result_d = {7'b0, sum_q};
                state_d  = WAIT_IN;
            end
            default: state_d = WAIT_IN;
        endcase
    end

    always_ff @(posedge CLK100MHZ or posedge BTNC) begin
        if (BTNC) begin
            state_q   <= WAIT_IN;
            btnl_s1_q <= 1'b0;
            btnl_s2_q <= 1'b0;
            btnr_s1_q <= 1'b0;
            btnr_s2_q <= 1'b0;
            opa_q     <= '0;
            opb_q     <= '0;
            sum_q     <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            btnl_s1_q <= btnl_s1_d;
            btnl_s2_q <= btnl_s2_d;
            btnr_s1_q <= btnr_s1_d;
            btnr_s2_q <= btnr_s2_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sum_q     <= sum_d;
            result_q  <= result_d;
        end
    end

`ifdef OPERAND_DISPLAY_EN
    assign disp_value = {opa_q, opb_q, result_q};
    assign disp_blank = 8'h00;
`else
    assign disp_value = {16'h0000, result_q};
    assign disp_blank = 8'hF0;
`endif

    seg7_scan #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk   (CLK100MHZ),
        .rst   (BTNC),
        .value (disp_value),
        .blank (disp_blank),
        .an    (AN),
        .seg   (A2G)
    );

endmodule

// File: tb/tb_cpu_io_top.sv
module tb_cpu_io_top;
    import cpu_io_pkg::*;

    logic        clk;
    logic        BTNC, BTNL, BTNR;
    logic [15:0] SW;
    logic [7:0]  AN;
    logic [6:0]  A2G;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    logic [15:0] exp_q[$];
    logic        pending = 1'b0;

    localparam logic [6:0] S0 = 7'b0000001;
    localparam logic [6:0] S1 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1001100;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SC = 7'b0110001;
    localparam logic [6:0] SE = 7'b0110000;
    localparam logic [6:0] SF = 7'b0111000;

    cpu_io_top #(
        .SCAN_BITS (3)
    ) dut (
        .CLK100MHZ (clk),
        .BTNC      (BTNC),
        .BTNL      (BTNL),
        .BTNR      (BTNR),
        .SW        (SW),
        .AN        (AN),
        .A2G       (A2G)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a WRITE seen at a falling edge means the result
    // register updates on the next rising edge; compare one edge later.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (pending) begin
                pending = 1'b0;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("result", {16'h0, dut.result_q}, {16'h0, e});
                end
            end
            if (dut.state_q == WRITE && !BTNC) pending = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        BTNC = 1'b1;
        @(negedge clk);
        BTNC = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int unsigned n = 0;
        while (exp_q.size() > 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timeout, %0d results still expected", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_digit(input int unsigned idx, input logic [6:0] exp_seg);
        int unsigned n = 0;
        logic [7:0] want;
        want = ~(8'b1 << idx);
        while (AN !== want && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (AN !== want) check($sformatf("digit%0d_slot", idx), {24'h0, AN}, {24'h0, want});
        else check($sformatf("digit%0d_seg", idx), {25'h0, A2G}, {25'h0, exp_seg});
    endtask

    task automatic sweep();
        int unsigned n = 0;
        logic [7:0] want;
        while (AN !== 8'hFE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("sweep_start", {24'h0, AN}, 32'h0000_00FE);
        for (int unsigned i = 1; i <= 8; i++) begin
            @(negedge clk);
            want = ~(8'b1 << (i % 8));
`ifndef OPERAND_DISPLAY_EN
            if ((i % 8) >= 4) want = 8'hFF;
`endif
            check($sformatf("sweep_%0d", i), {24'h0, AN}, {24'h0, want});
        end
    endtask

    initial begin
        int unsigned n;
        BTNC = 1'b1;
        BTNL = 1'b0;
        BTNR = 1'b0;
        SW   = 16'h0000;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_an",     {24'h0, AN},  32'h0000_00FE);
        check("rst_a2g",    {25'h0, A2G}, 32'h0000_0001);
        check("rst_result", {16'h0, dut.result_q}, 32'h0);
        check("rst_state",  32'(dut.state_q), 32'(WAIT_IN));
        BTNC = 1'b0;
        @(negedge clk);
        check("post_rst_an",  {24'h0, AN},  32'h0000_00FE);
        check("post_rst_a2g", {25'h0, A2G}, 32'h0000_0001);

        // Basic add: 0x04 + 0x08 = 0x0C
        SW = 16'h0408;
        do_reset();
        exp_q.push_back(16'h000C);
        BTNL = 1'b1;
        BTNR = 1'b1;
        wait_drain("basic");
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (10) @(negedge clk);
        check_digit(0, SC);
        check_digit(1, S0);
        check_digit(2, S0);
        check_digit(3, S0);
`ifdef OPERAND_DISPLAY_EN
        check_digit(4, S8);
        check_digit(5, S0);
        check_digit(6, S4);
        check_digit(7, S0);
`endif
        sweep();

        // Handshake ordering: parks in WAIT_OUT until BTNL
        SW = 16'h1020;
        do_reset();
        BTNR = 1'b1;
        repeat (10) @(negedge clk);
        check("park_state",  32'(dut.state_q), 32'(WAIT_OUT));
        check("park_result", {16'h0, dut.result_q}, 32'h0);
        exp_q.push_back(16'h0030);
        BTNL = 1'b1;
        wait_drain("handshake");
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (10) @(negedge clk);

        // Overflow: 0xFF + 0xFF = 0x1FE
        SW = 16'hFFFF;
        do_reset();
        exp_q.push_back(16'h01FE);
        BTNL = 1'b1;
        BTNR = 1'b1;
        wait_drain("overflow");
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (10) @(negedge clk);
        check_digit(0, SE);
        check_digit(1, SF);
        check_digit(2, S1);
        check_digit(3, S0);

        // Mid-operation reset while in ADD; result 0x1FE must be cleared
        SW = 16'h1234;
        BTNL = 1'b1;
        BTNR = 1'b1;
        n = 0;
        while (dut.state_q != ADD && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("reach_add", 32'(dut.state_q), 32'(ADD));
        BTNC = 1'b1;
        #1;
        check("midrst_result", {16'h0, dut.result_q}, 32'h0);
        check("midrst_state",  32'(dut.state_q), 32'(WAIT_IN));
        check("midrst_sum",    {23'h0, dut.sum_q}, 32'h0);
        @(negedge clk);
        BTNC = 1'b0;
        exp_q.push_back(16'h0046);
        wait_drain("after_midrst");
        BTNL = 1'b0;
        BTNR = 1'b0;
        repeat (5) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
